// File: rtl/uart_echo_fifo.sv
// UART loopback: 2-flop synchronized receiver -> FIFO -> transmit serializer.
// Define UART_PARITY_EN to add an even-parity bit on RX and TX and the parity_err flag.
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_AW      = 4
) (
  input  logic                 clk,
  input  logic                 sw_reset,
  input  logic                 RxD,
  input  logic                 rx_en,
  input  logic                 tx_en,
  input  logic                 clear_flags,
  output logic                 TxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 tx_busy,
  output logic                 overflow,
`ifdef UART_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(DATA_BITS + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]    B_LAST = BW'(DATA_BITS - 1);
  localparam logic [FIFO_AW:0] FULL   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  logic rx_meta_q, rx_sync_q;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic push_req, push, pop, ovf_set, frm_set;

  tx_state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic txd_q, txd_d;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic overflow_q, overflow_d, frame_err_q, frame_err_d;

`ifdef UART_PARITY_EN
  logic rx_par_bad_q, rx_par_bad_d, par_set, tx_par_q, tx_par_d, parity_err_q, parity_err_d;
`endif

  // ---------------- receiver ----------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    push_req   = 1'b0;
    frm_set    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    par_set      = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q && rx_en) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == C_HALF) begin
        // a start bit gone high by mid-bit is a line glitch, not a frame
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == C_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + BW'(1);
`ifdef UART_PARITY_EN
        if (rx_bit_q == B_LAST) rx_state_d = RX_PAR;
`else
        if (rx_bit_q == B_LAST) rx_state_d = RX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PAR: if (rx_cnt_q == C_LAST) begin
        rx_cnt_d     = '0;
        rx_par_bad_d = rx_sync_q ^ (^rx_shift_q);
        rx_state_d   = RX_STOP;
      end
`endif
      RX_STOP: if (rx_cnt_q == C_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (!rx_sync_q) frm_set = 1'b1;
`ifdef UART_PARITY_EN
        else if (rx_par_bad_q) par_set = 1'b1;
`endif
        else begin
          push_req  = 1'b1;
          rx_data_d = rx_shift_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  always_comb begin
    pop      = (tx_state_q == TX_LOAD) && (count_q != '0);
    push     = push_req && ((count_q != FULL) || pop);
    ovf_set  = push_req && !push;
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + (FIFO_AW + 1)'(1);
    if (pop && !push) count_d = count_q - (FIFO_AW + 1)'(1);
    // set beats a coincident clear
    overflow_d  = (overflow_q & ~clear_flags) | ovf_set;
    frame_err_d = (frame_err_q & ~clear_flags) | frm_set;
`ifdef UART_PARITY_EN
    parity_err_d = (parity_err_q & ~clear_flags) | par_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------- transmitter ----------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_en && count_q != '0) tx_state_d = TX_LOAD;
      end
      TX_LOAD: begin
        tx_shift_d = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
        tx_par_d   = ^mem_q[rd_ptr_q];
`endif
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txd_d      = 1'b0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == C_LAST) begin
        tx_cnt_d   = '0;
        txd_d      = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == C_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + BW'(1);
        if (tx_bit_q == B_LAST) begin
`ifdef UART_PARITY_EN
          txd_d      = tx_par_q;
          tx_state_d = TX_PAR;
`else
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          txd_d      = tx_shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      TX_PAR: if (tx_cnt_q == C_LAST) begin
        tx_cnt_d   = '0;
        txd_d      = 1'b1;
        tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tx_cnt_q == C_LAST) begin
        // chain straight into the next pop to keep bursts gap-free
        tx_cnt_d   = '0;
        txd_d      = 1'b1;
        tx_state_d = (tx_en && count_q != '0) ? TX_LOAD : TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sw_reset) begin
    if (sw_reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
      tx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= RxD;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
      tx_par_q     <= tx_par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign TxD        = txd_q;
  assign rx_data    = rx_data_q;
  assign fifo_count = count_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo (16 clks/bit, 8 data bits, 4-entry FIFO).
module tb_uart_echo_fifo;
  localparam int C = 16, DB = 8, AW = 2;
  // RxD start driven after edge k -> TxD echo falls at edge k+157
  localparam int ECHO_LAT = 157;
  // stop bit + LOAD cycle between consecutive TX start edges
  localparam int TX_PITCH = 161;

  logic clk = 1'b0;
  logic sw_reset, RxD, rx_en, tx_en, clear_flags;
  logic TxD, tx_busy, overflow, frame_err;
  logic [DB-1:0] rx_data;
  logic [AW:0] fifo_count;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  uart_echo_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .FIFO_AW(AW)) dut (
    .clk(clk), .sw_reset(sw_reset), .RxD(RxD), .rx_en(rx_en), .tx_en(tx_en),
    .clear_flags(clear_flags), .TxD(TxD), .rx_data(rx_data), .fifo_count(fifo_count),
    .tx_busy(tx_busy), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // all RX drivers start just after a rising edge
  task automatic rx_bit(input logic v);
    RxD = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < DB; i++) rx_bit(b[i]);
    rx_bit(stop);
    RxD = 1'b1;
  endtask

  // waits (bounded) for a TX start edge and samples the frame mid-bit
  task automatic get_frame(output logic [7:0] b, output logic framing_ok,
                           output int fall_cyc, output logic busy, output logic found);
    logic s0, sp;
    found = 1'b0; b = '0; framing_ok = 1'b0; fall_cyc = -1; busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (TxD === 1'b0) begin found = 1'b1; break; end
    end
    if (found) begin
      fall_cyc = cyc;
      repeat (C / 2) @(negedge clk);
      s0 = TxD; busy = tx_busy;
      for (int i = 0; i < DB; i++) begin
        repeat (C) @(negedge clk);
        b[i] = TxD;
      end
      repeat (C) @(negedge clk);
      sp = TxD;
      framing_ok = (s0 === 1'b0) && (sp === 1'b1);
    end
  endtask

  task automatic sync_in();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    sync_in();
    clear_flags = 1'b1;
    sync_in();
    clear_flags = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    sw_reset = 1'b1; RxD = 1'b1; rx_en = 1'b1; tx_en = 1'b1; clear_flags = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({TxD, tx_busy, overflow, frame_err} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_bits: TxD/busy/ovf/ferr got %b want 1000", {TxD, tx_busy, overflow, frame_err});
    end
    n_cmp++; if (rx_data !== 8'h00 || fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL reset_data: rx_data %h count %0d want 00 / 0", rx_data, fifo_count);
    end
    sync_in();
    sw_reset = 1'b0;
    repeat (4) sync_in();
  endtask

  task automatic test_echo();
    logic [7:0] b; logic ok, busy, found; int fall, k;
    sync_in();
    k = cyc;
    fork
      send_byte(8'hA5, 1'b1);
      get_frame(b, ok, fall, busy, found);
    join
    n_cmp++; if (!found || b !== 8'hA5 || !ok) begin
      n_bad++; $display("FAIL echo_a5: byte %h framing %b found %b want a5 1 1", b, ok, found);
    end
    n_cmp++; if (fall - k !== ECHO_LAT) begin
      n_bad++; $display("FAIL echo_latency: got %0d want %0d", fall - k, ECHO_LAT);
    end
    n_cmp++; if (busy !== 1'b1) begin
      n_bad++; $display("FAIL echo_busy: got %b want 1", busy);
    end
    n_cmp++; if (rx_data !== 8'hA5) begin
      n_bad++; $display("FAIL echo_rx_data: got %h want a5", rx_data);
    end
    repeat (12) @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd0 || tx_busy !== 1'b0 || TxD !== 1'b1) begin
      n_bad++; $display("FAIL echo_idle: count %0d busy %b TxD %b want 0 0 1", fifo_count, tx_busy, TxD);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b; logic ok, busy, found; int fall, prev;
    tx_en = 1'b0;
    sync_in();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    repeat (8) @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd4 || rx_data !== 8'h04 || TxD !== 1'b1) begin
      n_bad++; $display("FAIL b2b_fill: count %0d rx_data %h TxD %b want 4 04 1", fifo_count, rx_data, TxD);
    end
    sync_in();
    tx_en = 1'b1;
    prev = -1;
    for (int i = 1; i <= 4; i++) begin
      get_frame(b, ok, fall, busy, found);
      n_cmp++; if (!found || b !== 8'(i) || !ok) begin
        n_bad++; $display("FAIL b2b_order%0d: byte %h framing %b want %h 1", i, b, ok, 8'(i));
      end
      if (prev >= 0) begin
        n_cmp++; if (fall - prev !== TX_PITCH) begin
          n_bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, fall - prev, TX_PITCH);
        end
      end
      prev = fall;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [7:0] b; logic ok, busy, found; int fall;
    tx_en = 1'b0;
    sync_in();
    for (int i = 1; i <= 6; i++) send_byte(8'h10 + 8'(i), 1'b1);
    repeat (8) @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd4 || overflow !== 1'b1 || rx_data !== 8'h16) begin
      n_bad++; $display("FAIL ovf_fill: count %0d ovf %b rx_data %h want 4 1 16", fifo_count, overflow, rx_data);
    end
    sync_in();
    tx_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      get_frame(b, ok, fall, busy, found);
      n_cmp++; if (!found || b !== 8'h10 + 8'(i) || !ok) begin
        n_bad++; $display("FAIL ovf_drain%0d: byte %h want %h", i, b, 8'h10 + 8'(i));
      end
    end
    repeat (12) @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd0 || overflow !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drained: count %0d ovf %b busy %b want 0 1 0", fifo_count, overflow, tx_busy);
    end
    pulse_clear();
    n_cmp++; if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b; logic ok, busy, found; int fall;
    sync_in();
    RxD = 1'b0;
    repeat (4) sync_in();
    RxD = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd0 || frame_err !== 1'b0 || overflow !== 1'b0 || rx_data !== 8'h16 || TxD !== 1'b1) begin
      n_bad++; $display("FAIL glitch: count %0d ferr %b ovf %b rx_data %h TxD %b want 0 0 0 16 1",
                        fifo_count, frame_err, overflow, rx_data, TxD);
    end
    sync_in();
    fork
      send_byte(8'h77, 1'b1);
      get_frame(b, ok, fall, busy, found);
    join
    n_cmp++; if (!found || b !== 8'h77 || !ok || rx_data !== 8'h77) begin
      n_bad++; $display("FAIL glitch_recover: echo %h rx_data %h want 77 77", b, rx_data);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_frame_err();
    sync_in();
    send_byte(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    n_cmp++; if (frame_err !== 1'b1 || fifo_count !== 3'd0 || rx_data !== 8'h77 || TxD !== 1'b1) begin
      n_bad++; $display("FAIL frame_err: ferr %b count %0d rx_data %h TxD %b want 1 0 77 1",
                        frame_err, fifo_count, rx_data, TxD);
    end
    pulse_clear();
    n_cmp++; if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL frame_err_clear: got %b want 0", frame_err);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b; logic ok, busy, found; int fall, k;
    sync_in();
    fork
      send_byte(8'hC1, 1'b1);
      get_frame(b, ok, fall, busy, found);
    join_any
    // get_frame is still sampling; reset lands in data bit 1 (a 0 bit)
    disable fork;
    wait (TxD === 1'b0 || cyc > 100000);
    repeat (43) @(posedge clk);
    #1;
    n_cmp++; if (TxD !== 1'b0 || tx_busy !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: TxD %b busy %b want 0 1", TxD, tx_busy);
    end
    sw_reset = 1'b1;
    #1;
    n_cmp++; if (TxD !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_tx: TxD %b busy %b want 1 0", TxD, tx_busy);
    end
    repeat (3) sync_in();
    sw_reset = 1'b0;
    RxD = 1'b1;
    repeat (4) sync_in();
    n_cmp++; if (fifo_count !== 3'd0 || rx_data !== 8'h00) begin
      n_bad++; $display("FAIL post_reset: count %0d rx_data %h want 0 00", fifo_count, rx_data);
    end
    k = cyc;
    fork
      send_byte(8'h5A, 1'b1);
      get_frame(b, ok, fall, busy, found);
    join
    n_cmp++; if (!found || b !== 8'h5A || !ok || fall - k !== ECHO_LAT) begin
      n_bad++; $display("FAIL echo_after_reset: byte %h framing %b lat %0d want 5a 1 %0d", b, ok, fall - k, ECHO_LAT);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_echo();
    test_back_to_back();
    test_overflow();
    test_glitch();
    test_frame_err();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
